cve2_sleep_ctrl: RTL and testbench
==================================

CVE2_SLEEP_CTRL -- requirements
Module: cve2_sleep_ctrl

Interface
REQ-001 SHALL have parameter NumWakeSrc, default 4: number of maskable wake sources, range 1..16.
REQ-002 SHALL have parameter IdleDelayW, default 4: width of the idle-hysteresis count.
REQ-003 SHALL have parameter WakeDelay, default 2: settle cycles between wake and clock enable, range 1..15.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk_i, input, 1 bit: sole clock.
REQ-006 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port test_en_i, input, 1 bit: forces the clock enable on.
REQ-008 SHALL have port fetch_enable_i, input, 1 bit: fetch-enable request, made sticky internally.
REQ-009 SHALL have port core_busy_i, input, 1 bit: core is doing work.
REQ-010 SHALL have port debug_req_i, input, 1 bit: debug request, an unmaskable wake source.
REQ-011 SHALL have port irq_nm_i, input, 1 bit: NMI, an unmaskable wake source.
REQ-012 SHALL have port wake_i, input, NumWakeSrc bits: interrupt-pending wake sources.
REQ-013 SHALL have port wake_mask_i, input, NumWakeSrc bits: a 1 enables the matching wake_i bit.
REQ-014 SHALL have port idle_delay_i, input, IdleDelayW bits: idle cycles required before gating.
REQ-015 SHALL have port clock_en_o, output, 1 bit: enable for the core clock gate.
REQ-016 SHALL have port core_sleep_o, output, 1 bit: core is gated and asleep.
REQ-017 SHALL have port fetch_enable_o, output, 1 bit: sticky fetch enable for the core.
REQ-018 SHALL have port wake_cause_o, output, NumWakeSrc+2 bits: {irq_nm, debug_req, masked wake_i} captured at the last wake.

Function
REQ-019 SHALL define wake_evt = debug_req_i | irq_nm_i | OR-reduce(wake_i & wake_mask_i), combinational with no pipelining.
REQ-020 SHALL implement FSM states OFF, RUN, DRAIN, SLEEP and WAKE.
REQ-021 SHALL hold fetch_enable_o as a sticky register: set on any edge with fetch_enable_i=1, cleared only by reset.
REQ-022 SHALL, in OFF, go to RUN on the same edge at which fetch_enable_i=1 is sampled; otherwise it stays in OFF.
REQ-023 SHALL, in RUN with core_busy_i=1 or wake_evt=1, stay in RUN; the wake condition has priority over gating.
REQ-024 SHALL, in RUN with core_busy_i=0, wake_evt=0 and idle_delay_i=0, go to SLEEP.
REQ-025 SHALL, in RUN with core_busy_i=0, wake_evt=0 and idle_delay_i≠0, go to DRAIN and load the counter with idle_delay_i.
REQ-026 SHALL sample idle_delay_i only on the RUN->DRAIN transition; changes during DRAIN are ignored.
REQ-027 SHALL, in DRAIN with core_busy_i=1 or wake_evt=1, return to RUN and discard the counter.
REQ-028 SHALL, in DRAIN otherwise, go to SLEEP when the counter equals 1, else decrement the counter; DRAIN therefore lasts exactly idle_delay_i cycles.
REQ-029 SHALL, in SLEEP with wake_evt=1, go to WAKE, load the settle counter with WakeDelay, and capture wake_cause_o = {irq_nm_i, debug_req_i, wake_i & wake_mask_i}.
REQ-030 SHALL, in SLEEP with wake_evt=0, stay in SLEEP; core_busy_i is ignored in SLEEP.
REQ-031 SHALL apply wake_mask_i changes during SLEEP immediately.
REQ-032 SHALL, in WAKE, decrement the settle counter and go to RUN when it equals 1, so WAKE lasts exactly WakeDelay cycles; wake inputs are ignored in WAKE.
REQ-033 SHALL hold wake_cause_o until the next SLEEP->WAKE transition.
REQ-034 SHALL drive clock_en_o = (state is RUN or DRAIN) | test_en_i; the state term comes straight from a register with no input-to-output path.
REQ-035 SHALL drive core_sleep_o = 1 only in SLEEP, and 0 in WAKE, OFF, RUN and DRAIN.
REQ-036 SHALL keep both counters IdleDelayW and 4 bits wide respectively; they never wrap below 1 because the exit is taken at 1.

Reset
REQ-037 SHALL, on any edge with rst_i=1, force state OFF, both counters to 0, fetch_enable_o=0 and wake_cause_o=0; this applies from every state, including mid-DRAIN and mid-WAKE.
REQ-038 SHALL, during and after reset, drive core_sleep_o=0 and clock_en_o=test_en_i.
REQ-039 SHALL have rst_i take priority over fetch_enable_i when both are high on the same edge.

Verification
REQ-040 SHALL be covered by a bench test: reset, then fetch_enable_i pulse at cycle 3 -> fetch_enable_o=1 and clock_en_o=1 from cycle 4, with fetch_enable_o held after fetch_enable_i drops.
REQ-041 SHALL be covered by a bench test: idle_delay_i=3, core_busy_i falls at cycle t, no wake -> clock_en_o=1 through t+3, clock_en_o=0 and core_sleep_o=1 at t+4.
REQ-042 SHALL be covered by a bench test: idle_delay_i=3 with core_busy_i pulsing high at DRAIN cycle 2 -> return to RUN, and the full 3-cycle DRAIN restarts on the next idle.
REQ-043 SHALL be covered by a bench test: in SLEEP, wake_i=4'b0100 with mask 4'b0000 -> stays in SLEEP; with mask 4'b0100 -> WAKE, wake_cause_o=6'b000100, clock_en_o=1 exactly 2 cycles later (WakeDelay=2).
REQ-044 SHALL be covered by a bench test: in RUN with core_busy_i=0 and debug_req_i=1 -> never enters DRAIN or SLEEP; test_en_i=1 in SLEEP -> clock_en_o=1 and core_sleep_o=1.
REQ-045 SHALL be covered by a bench test: rst_i asserted mid-WAKE -> OFF, fetch_enable_o=0 and wake_cause_o=0 on the next cycle, with no RUN entry until a new fetch_enable_i.

Source files
------------

// File: rtl/cve2_sleep_ctrl.sv
// cve2_sleep_ctrl: idle/sleep sequencer driving the core clock gate.
// Sticky fetch enable, idle hysteresis, maskable wake and settle delay.
//
// Ports:
//   clk_i, rst_i      sole clock, synchronous active-high reset
//   test_en_i         forces clock_en_o on
//   fetch_enable_i    fetch-enable request (made sticky)
//   core_busy_i       core is doing work
//   debug_req_i       unmaskable wake source
//   irq_nm_i          unmaskable wake source
//   wake_i            interrupt-pending wake sources
//   wake_mask_i       1 enables the matching wake_i bit
//   idle_delay_i      idle cycles required before gating
//   clock_en_o        core clock gate enable
//   core_sleep_o      core is gated and asleep
//   fetch_enable_o    sticky fetch enable
//   wake_cause_o      {irq_nm, debug_req, masked wake} at last wake
module cve2_sleep_ctrl #(
  parameter int unsigned NumWakeSrc = 4,
  parameter int unsigned IdleDelayW = 4,
  parameter int unsigned WakeDelay  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  test_en_i,
  input  logic                  fetch_enable_i,
  input  logic                  core_busy_i,
  input  logic                  debug_req_i,
  input  logic                  irq_nm_i,
  input  logic [NumWakeSrc-1:0] wake_i,
  input  logic [NumWakeSrc-1:0] wake_mask_i,
  input  logic [IdleDelayW-1:0] idle_delay_i,
  output logic                  clock_en_o,
  output logic                  core_sleep_o,
  output logic                  fetch_enable_o,
  output logic [NumWakeSrc+1:0] wake_cause_o
);

  typedef enum logic [2:0] {
    OFF,
    RUN,
    DRAIN,
    SLEEP,
    WAKE
  } state_e;

  localparam logic [3:0] WakeLoad = 4'(WakeDelay);
  localparam logic [IdleDelayW-1:0] IdleOne = IdleDelayW'(1);

  state_e                  state_q, state_d;
  logic [IdleDelayW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [3:0]              wake_cnt_q, wake_cnt_d;
  logic [NumWakeSrc+1:0]   cause_q, cause_d;
  logic                    fetch_en_q;
  logic                    clk_on_q;
  logic                    sleep_q;
  logic [NumWakeSrc-1:0]   wake_masked;
  logic                    wake_evt;

  assign wake_masked = wake_i & wake_mask_i;
  assign wake_evt    = debug_req_i | irq_nm_i | (|wake_masked);

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    cause_d    = cause_q;
    unique case (state_q)
      OFF: begin
        if (fetch_enable_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // wake pending outranks gating
        if (!core_busy_i && !wake_evt) begin
          if (idle_delay_i == '0) begin
            state_d = SLEEP;
          end else begin
            state_d    = DRAIN;
            idle_cnt_d = idle_delay_i;
          end
        end
      end
      DRAIN: begin
        if (core_busy_i || wake_evt) begin
          state_d    = RUN;
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IdleOne) begin
          state_d    = SLEEP;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q - IdleOne;
        end
      end
      SLEEP: begin
        if (wake_evt) begin
          state_d    = WAKE;
          wake_cnt_d = WakeLoad;
          cause_d    = {irq_nm_i, debug_req_i, wake_masked};
        end
      end
      WAKE: begin
        if (wake_cnt_q == 4'd1) begin
          state_d    = RUN;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = OFF;
      end
    endcase
  end

  // Output flags are registered from the next state so the
  // gate enable has no combinational path from the inputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= OFF;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      cause_q    <= '0;
      fetch_en_q <= 1'b0;
      clk_on_q   <= 1'b0;
      sleep_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      cause_q    <= cause_d;
      if (fetch_enable_i) begin
        fetch_en_q <= 1'b1;
      end
      clk_on_q   <= (state_d == RUN) || (state_d == DRAIN);
      sleep_q    <= (state_d == SLEEP);
    end
  end

  assign clock_en_o     = clk_on_q | test_en_i;
  assign core_sleep_o   = sleep_q;
  assign fetch_enable_o = fetch_en_q;
  assign wake_cause_o   = cause_q;

endmodule

// File: tb/tb_cve2_sleep_ctrl.sv
// tb_cve2_sleep_ctrl: directed bench for cve2_sleep_ctrl.
// Linear stimulus with immediate-assertion checks.
module tb_cve2_sleep_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       test_en_i;
  logic       fetch_enable_i;
  logic       core_busy_i;
  logic       debug_req_i;
  logic       irq_nm_i;
  logic [3:0] wake_i;
  logic [3:0] wake_mask_i;
  logic [3:0] idle_delay_i;
  logic       clock_en_o;
  logic       core_sleep_o;
  logic       fetch_enable_o;
  logic [5:0] wake_cause_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  cve2_sleep_ctrl #(
    .NumWakeSrc(4),
    .IdleDelayW(4),
    .WakeDelay (2)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .test_en_i     (test_en_i),
    .fetch_enable_i(fetch_enable_i),
    .core_busy_i   (core_busy_i),
    .debug_req_i   (debug_req_i),
    .irq_nm_i      (irq_nm_i),
    .wake_i        (wake_i),
    .wake_mask_i   (wake_mask_i),
    .idle_delay_i  (idle_delay_i),
    .clock_en_o    (clock_en_o),
    .core_sleep_o  (core_sleep_o),
    .fetch_enable_o(fetch_enable_o),
    .wake_cause_o  (wake_cause_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic ce,
                         input logic sl);
    chk({tag, ".clk_en"}, {7'd0, clock_en_o}, {7'd0, ce});
    chk({tag, ".sleep"}, {7'd0, core_sleep_o}, {7'd0, sl});
  endtask

  initial begin
    rst_i          = 1'b1;
    test_en_i      = 1'b0;
    fetch_enable_i = 1'b0;
    core_busy_i    = 1'b0;
    debug_req_i    = 1'b0;
    irq_nm_i       = 1'b0;
    wake_i         = '0;
    wake_mask_i    = '0;
    idle_delay_i   = 4'd3;

    tick();
    tick();
    chk_out("rst", 1'b0, 1'b0);
    chk("rst.fetch", {7'd0, fetch_enable_o}, 8'd0);
    chk("rst.cause", {2'd0, wake_cause_o}, 8'd0);
    test_en_i = 1'b1;
    #1;
    chk_out("rst.test_en", 1'b1, 1'b0);
    test_en_i = 1'b0;

    // cycles 1..2 idle in OFF, fetch pulse at cycle 3
    rst_i = 1'b0;
    tick();
    tick();
    chk_out("off", 1'b0, 1'b0);
    chk("off.fetch", {7'd0, fetch_enable_o}, 8'd0);
    fetch_enable_i = 1'b1;
    core_busy_i    = 1'b1;
    tick();
    fetch_enable_i = 1'b0;
    chk_out("run.entry", 1'b1, 1'b0);
    chk("run.fetch", {7'd0, fetch_enable_o}, 8'd1);
    tick();
    chk("run.fetch_held", {7'd0, fetch_enable_o}, 8'd1);
    chk_out("run.busy", 1'b1, 1'b0);

    // idle drain of 3 cycles, delay change mid-drain ignored
    core_busy_i = 1'b0;
    tick();
    chk_out("drain1", 1'b1, 1'b0);
    idle_delay_i = 4'd9;
    tick();
    chk_out("drain2", 1'b1, 1'b0);
    tick();
    chk_out("drain3", 1'b1, 1'b0);
    tick();
    chk_out("sleep", 1'b0, 1'b1);
    idle_delay_i = 4'd3;

    // busy ignored while asleep, masked wake ignored
    core_busy_i = 1'b1;
    tick();
    chk_out("sleep.busy", 1'b0, 1'b1);
    core_busy_i = 1'b0;
    wake_i      = 4'b0100;
    wake_mask_i = 4'b0000;
    tick();
    chk_out("sleep.masked", 1'b0, 1'b1);

    // unmask: wake, clock back 2 cycles later
    wake_mask_i = 4'b0100;
    tick();
    chk_out("wake0", 1'b0, 1'b0);
    chk("wake0.cause", {2'd0, wake_cause_o}, 8'b000100);
    wake_i      = 4'b0000;
    wake_mask_i = 4'b0000;
    core_busy_i = 1'b1;
    tick();
    chk_out("wake1", 1'b0, 1'b0);
    tick();
    chk_out("wake.run", 1'b1, 1'b0);

    // busy pulse at drain cycle 2 restarts full drain
    core_busy_i = 1'b0;
    tick();
    chk_out("redrain1", 1'b1, 1'b0);
    tick();
    core_busy_i = 1'b1;
    tick();
    core_busy_i = 1'b0;
    chk_out("abort", 1'b1, 1'b0);
    tick();
    chk_out("restart1", 1'b1, 1'b0);
    tick();
    chk_out("restart2", 1'b1, 1'b0);
    tick();
    chk_out("restart3", 1'b1, 1'b0);
    tick();
    chk_out("resleep", 1'b0, 1'b1);

    // test enable overrides gate while asleep
    test_en_i = 1'b1;
    #1;
    chk_out("sleep.test_en", 1'b1, 1'b1);
    test_en_i = 1'b0;

    // NMI wake, wake inputs ignored during WAKE
    irq_nm_i = 1'b1;
    tick();
    irq_nm_i    = 1'b0;
    chk("nmi.cause", {2'd0, wake_cause_o}, 8'b100000);
    debug_req_i = 1'b1;
    core_busy_i = 1'b1;
    tick();
    debug_req_i = 1'b0;
    chk_out("nmi.wake1", 1'b0, 1'b0);
    chk("nmi.cause_held", {2'd0, wake_cause_o}, 8'b100000);
    tick();
    chk_out("nmi.run", 1'b1, 1'b0);

    // pending debug request blocks gating
    core_busy_i  = 1'b0;
    debug_req_i  = 1'b1;
    idle_delay_i = 4'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("dbg.hold", 1'b1, 1'b0);
    end
    debug_req_i = 1'b0;
    tick();
    chk_out("zero_delay.sleep", 1'b0, 1'b1);
    chk("cause.hold", {2'd0, wake_cause_o}, 8'b100000);

    // partial mask capture, then reset mid-WAKE
    wake_i      = 4'b1111;
    wake_mask_i = 4'b0101;
    tick();
    wake_i      = 4'b0000;
    wake_mask_i = 4'b0000;
    chk("mask.cause", {2'd0, wake_cause_o}, 8'b000101);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk_out("wake.rst", 1'b0, 1'b0);
    chk("wake.rst.fetch", {7'd0, fetch_enable_o}, 8'd0);
    chk("wake.rst.cause", {2'd0, wake_cause_o}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("post_rst.off", 1'b0, 1'b0);
    end

    // reset beats fetch enable on the same edge
    rst_i          = 1'b1;
    fetch_enable_i = 1'b1;
    tick();
    rst_i          = 1'b0;
    fetch_enable_i = 1'b0;
    chk("rst_prio.fetch", {7'd0, fetch_enable_o}, 8'd0);
    chk_out("rst_prio", 1'b0, 1'b0);
    tick();
    chk_out("rst_prio.off", 1'b0, 1'b0);
    fetch_enable_i = 1'b1;
    core_busy_i    = 1'b1;
    tick();
    fetch_enable_i = 1'b0;
    chk_out("refetch", 1'b1, 1'b0);
    chk("refetch.fetch", {7'd0, fetch_enable_o}, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
